// File: rtl/alu_writeback.sv
// Retire stage behind the integer ALU: in-order result queue feeding RF writes, icc/Y updates and tag-overflow traps.
// Optional zero-latency path for an empty queue is enabled by defining WB_BYPASS_EN.
module alu_writeback #(
    parameter int          DEPTH      = 2,
    parameter logic [7:0]  TT_TAG_OVF = 8'h0A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_done,
    input  logic [31:0] alu_val,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_c,
    input  logic [31:0] alu_y,
    input  logic        alu_trap,
    input  logic [1:0]  ctx_op,
    input  logic [5:0]  ctx_op3,
    input  logic [4:0]  ctx_rd,
    output logic        wb_full,
    output logic        wb_empty,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        rf_wready,
    output logic [3:0]  icc,
    output logic [31:0] y_reg,
    output logic        trap_req,
    output logic [7:0]  trap_tt,
    output logic        wb_overflow
);
    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] val;
        logic [3:0]  flags;
        logic [31:0] y;
        logic        trap;
        logic [4:0]  rd;
        logic        cc_upd;
        logic        y_upd;
        logic        reg_wr;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   head_ptr, tail_ptr;
    logic [AW:0]     count;
    entry_t          in_e, hd;
    logic            hd_valid, no_wr, pop, pop_q, do_push, push_ok, flush;

    // Decode the instruction context once, at push time, so retire logic only sees update bits.
    always_comb begin
        in_e       = '0;
        in_e.val   = alu_val;
        in_e.flags = {alu_n, alu_z, alu_v, alu_c};
        in_e.y     = alu_y;
        in_e.trap  = alu_trap;
        in_e.rd    = ctx_rd;
        if (ctx_op == 2'b10) begin
            in_e.cc_upd = (ctx_op3[5:4] == 2'b01) ||
                          (ctx_op3 inside {6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100});
            in_e.y_upd  = ctx_op3 inside {6'b001010, 6'b001011, 6'b011010, 6'b011011, 6'b100100, 6'b110000};
            in_e.reg_wr = (ctx_rd != 5'd0) && (ctx_op3 != 6'b110000);
        end else if (ctx_op == 2'b00) begin
            in_e.reg_wr = (ctx_rd != 5'd0);
        end
    end

    assign wb_full  = (count == FULL_CNT);
    assign wb_empty = (count == '0);

`ifdef WB_BYPASS_EN
    logic bypass;
    assign bypass   = wb_empty & alu_done;
    assign hd       = bypass ? in_e : mem[head_ptr];
    assign hd_valid = !rst & (!wb_empty | alu_done);
    assign pop_q    = pop & !bypass;
    assign do_push  = alu_done & !(bypass & pop);
`else
    assign hd       = mem[head_ptr];
    assign hd_valid = !rst & !wb_empty;
    assign pop_q    = pop;
    assign do_push  = alu_done;
`endif

    // Write handshake: a write retires on rf_we & rf_wready; entries without a write retire on the first edge as head.
    assign rf_we    = hd_valid & hd.reg_wr & !hd.trap;
    assign no_wr    = hd_valid & (!hd.reg_wr | hd.trap);
    assign pop      = (rf_we & rf_wready) | no_wr;
    assign flush    = pop & hd.trap;
    assign push_ok  = do_push & (!wb_full | pop_q) & !flush;
    assign rf_waddr = rf_we ? hd.rd  : 5'd0;
    assign rf_wdata = rf_we ? hd.val : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr    <= '0;
            tail_ptr    <= '0;
            count       <= '0;
            icc         <= 4'h0;
            y_reg       <= 32'd0;
            trap_req    <= 1'b0;
            trap_tt     <= 8'h00;
            wb_overflow <= 1'b0;
        end else begin
            trap_req <= flush;
            trap_tt  <= flush ? TT_TAG_OVF : 8'h00;
            if (pop && !hd.trap) begin
                if (hd.cc_upd) icc   <= hd.flags;
                if (hd.y_upd)  y_reg <= hd.y;
            end
            if (flush) begin
                head_ptr <= '0;
                tail_ptr <= '0;
                count    <= '0;
            end else begin
                if (push_ok) tail_ptr <= tail_ptr + 1'b1;
                if (pop_q)   head_ptr <= head_ptr + 1'b1;
                count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_q};
            end
            if (do_push && wb_full && !pop_q) wb_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[tail_ptr] <= in_e;
    end
endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus random traffic against a queue-based reference model.
module tb_alu_writeback;
  localparam int DEPTH = 2;
  localparam int W     = 82;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_done;
  logic [31:0] alu_val;
  logic        alu_n, alu_z, alu_v, alu_c;
  logic [31:0] alu_y;
  logic        alu_trap;
  logic [1:0]  ctx_op;
  logic [5:0]  ctx_op3;
  logic [4:0]  ctx_rd;
  logic        wb_full, wb_empty, rf_we, rf_wready;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  icc;
  logic [31:0] y_reg;
  logic        trap_req;
  logic [7:0]  trap_tt;
  logic        wb_overflow;

  always #5 clk = ~clk;

  alu_writeback #(.DEPTH(DEPTH), .TT_TAG_OVF(8'h0A)) dut (
    .clk(clk), .rst(rst), .alu_done(alu_done), .alu_val(alu_val),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
    .alu_y(alu_y), .alu_trap(alu_trap), .ctx_op(ctx_op), .ctx_op3(ctx_op3),
    .ctx_rd(ctx_rd), .wb_full(wb_full), .wb_empty(wb_empty), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wready(rf_wready),
    .icc(icc), .y_reg(y_reg), .trap_req(trap_req), .trap_tt(trap_tt),
    .wb_overflow(wb_overflow)
  );

  // Entry layout: {val[81:50], flags[49:46], y[45:14], trap[13], op[12:11], op3[10:5], rd[4:0]}
  logic [W-1:0] exp_q[$];
  logic [3:0]   m_icc;
  logic [31:0]  m_y;
  logic         m_trap_req;
  logic         m_ovf;
  int           n_checks = 0;
  int           n_fail   = 0;

  // Returns {cc_upd, y_upd, reg_wr} straight from the instruction-class rules.
  function automatic logic [2:0] decode(input logic [1:0] op, input logic [5:0] op3, input logic [4:0] rd);
    logic cc, yu, wr;
    cc = 1'b0; yu = 1'b0; wr = 1'b0;
    if (op == 2'b10) begin
      cc = (op3[5:4] == 2'b01) || (op3 inside {6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100});
      yu = op3 inside {6'b001010, 6'b001011, 6'b011010, 6'b011011, 6'b100100, 6'b110000};
      wr = (rd != 5'd0) && (op3 != 6'b110000);
    end else if (op == 2'b00) begin
      wr = (rd != 5'd0);
    end
    return {cc, yu, wr};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_icc = 4'h0; m_y = 32'd0; m_trap_req = 1'b0; m_ovf = 1'b0;
  endtask

  // Drive one cycle, compare every output with the model, then advance the model across the edge.
  task automatic cycle(input logic done, input logic [31:0] val, input logic [3:0] f, input logic [31:0] y,
                       input logic trap, input logic [1:0] op, input logic [5:0] op3, input logic [4:0] rd,
                       input logic wready);
    logic [W-1:0] h;
    logic [2:0]   d;
    logic         e_we, pop, flush;
    alu_done = done; alu_val = val; {alu_n, alu_z, alu_v, alu_c} = f; alu_y = y;
    alu_trap = trap; ctx_op = op; ctx_op3 = op3; ctx_rd = rd; rf_wready = wready;
    #1;
    h = '0; d = '0; e_we = 1'b0;
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      d = decode(h[12:11], h[10:5], h[4:0]);
      e_we = d[0] && !h[13];
    end
    n_checks++;
    if (rf_we !== e_we) begin n_fail++; $display("FAIL rf_we: got %b expected %b t=%0t", rf_we, e_we, $time); end
    if (e_we) begin
      n_checks++;
      if (rf_waddr !== h[4:0]) begin n_fail++; $display("FAIL rf_waddr: got %0d expected %0d t=%0t", rf_waddr, h[4:0], $time); end
      n_checks++;
      if (rf_wdata !== h[81:50]) begin n_fail++; $display("FAIL rf_wdata: got %h expected %h t=%0t", rf_wdata, h[81:50], $time); end
    end
    n_checks++;
    if (wb_full !== (exp_q.size() == DEPTH)) begin n_fail++; $display("FAIL wb_full: got %b expected %b t=%0t", wb_full, exp_q.size() == DEPTH, $time); end
    n_checks++;
    if (wb_empty !== (exp_q.size() == 0)) begin n_fail++; $display("FAIL wb_empty: got %b expected %b t=%0t", wb_empty, exp_q.size() == 0, $time); end
    n_checks++;
    if (icc !== m_icc) begin n_fail++; $display("FAIL icc: got %h expected %h t=%0t", icc, m_icc, $time); end
    n_checks++;
    if (y_reg !== m_y) begin n_fail++; $display("FAIL y_reg: got %h expected %h t=%0t", y_reg, m_y, $time); end
    n_checks++;
    if (trap_req !== m_trap_req) begin n_fail++; $display("FAIL trap_req: got %b expected %b t=%0t", trap_req, m_trap_req, $time); end
    if (m_trap_req) begin
      n_checks++;
      if (trap_tt !== 8'h0A) begin n_fail++; $display("FAIL trap_tt: got %h expected 0a t=%0t", trap_tt, $time); end
    end
    n_checks++;
    if (wb_overflow !== m_ovf) begin n_fail++; $display("FAIL wb_overflow: got %b expected %b t=%0t", wb_overflow, m_ovf, $time); end
    @(posedge clk);
    pop = 1'b0; flush = 1'b0; m_trap_req = 1'b0;
    if (exp_q.size() > 0) pop = e_we ? wready : 1'b1;
    if (pop) begin
      if (h[13]) begin
        m_trap_req = 1'b1;
        exp_q.delete();
        flush = 1'b1;
      end else begin
        if (d[2]) m_icc = h[49:46];
        if (d[1]) m_y = h[45:14];
        void'(exp_q.pop_front());
      end
    end
    if (done && !flush) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({val, f, y, trap, op, op3, rd});
      else m_ovf = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic wready);
    cycle(1'b0, $urandom, 4'($urandom), $urandom, 1'b0, 2'b10, 6'b010000, 5'($urandom), wready);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    alu_done = 1'b0; alu_val = '0; {alu_n, alu_z, alu_v, alu_c} = 4'h0; alu_y = '0;
    alu_trap = 1'b0; ctx_op = 2'b00; ctx_op3 = '0; ctx_rd = '0; rf_wready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, icc, y_reg, trap_req, trap_tt, wb_overflow} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got we=%b addr=%0d data=%h icc=%h y=%h tr=%b tt=%h ovf=%b expected all zero",
                               rf_we, rf_waddr, rf_wdata, icc, y_reg, trap_req, trap_tt, wb_overflow); end
    n_checks++;
    if (wb_empty !== 1'b1 || wb_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%b full=%b expected 1 0", wb_empty, wb_full); end
    @(negedge clk);
  endtask

  task automatic test_addcc();
    cycle(1'b1, 32'd0, 4'b0100, 32'd0, 1'b0, 2'b10, 6'b010000, 5'd5, 1'b1);
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'd0)
      begin n_fail++; $display("FAIL addcc_write: got we=%b addr=%0d data=%h expected 1 5 0", rf_we, rf_waddr, rf_wdata); end
    idle(1'b1);
    n_checks++;
    if (icc !== 4'b0100) begin n_fail++; $display("FAIL addcc_icc: got %b expected 0100", icc); end
  endtask

  task automatic test_umul();
    cycle(1'b1, 32'h2, 4'b0000, 32'h1, 1'b0, 2'b10, 6'b001010, 5'd0, 1'b1);
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL umul_no_write: got %b expected 0", rf_we); end
    idle(1'b1);
    n_checks++;
    if (y_reg !== 32'h1 || icc !== 4'b0100) begin n_fail++; $display("FAIL umul_y: got y=%h icc=%b expected 1 0100", y_reg, icc); end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 32'hDEAD_BEEF, 4'h0, 32'h0, 1'b0, 2'b10, 6'b000000, 5'd9, 1'b0);
    n_checks++;
    if (rf_we !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got rf_we=%b expected 1", rf_we); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, icc, y_reg} !== '0 || wb_empty !== 1'b1)
      begin n_fail++; $display("FAIL areset_outputs: got we=%b addr=%0d data=%h icc=%h y=%h empty=%b expected 0s and empty=1",
                               rf_we, rf_waddr, rf_wdata, icc, y_reg, wb_empty); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h100 + i, 4'h0, 32'h0, 1'b0, 2'b10, 6'b000000, 5'(7 + i), 1'b0);
    n_checks++;
    if (wb_full !== 1'b1 || wb_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_state: got full=%b ovf=%b expected 1 1", wb_full, wb_overflow); end
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(7 + i) || rf_wdata !== 32'h100 + i)
        begin n_fail++; $display("FAIL overflow_drain%0d: got we=%b addr=%0d data=%h expected 1 %0d %h", i, rf_we, rf_waddr, rf_wdata, 7 + i, 32'h100 + i); end
      idle(1'b1);
    end
    n_checks++;
    if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL overflow_empty: got %b expected 1", wb_empty); end
  endtask

  task automatic test_trap();
    apply_reset();
    cycle(1'b1, 32'h11, 4'h0, 32'h0, 1'b0, 2'b10, 6'b000000, 5'd3, 1'b0);
    cycle(1'b1, 32'h22, 4'hF, 32'h0, 1'b1, 2'b10, 6'b100010, 5'd4, 1'b0);
    cycle(1'b1, 32'h33, 4'hF, 32'h0, 1'b0, 2'b10, 6'b010000, 5'd6, 1'b1);
    #1;
    n_checks++;
    if (rf_we !== 1'b0 || wb_full !== 1'b1) begin n_fail++; $display("FAIL trap_head: got we=%b full=%b expected 0 1", rf_we, wb_full); end
    idle(1'b1);
    n_checks++;
    if (trap_req !== 1'b1 || trap_tt !== 8'h0A || wb_empty !== 1'b1 || rf_we !== 1'b0 || icc !== 4'h0)
      begin n_fail++; $display("FAIL trap_pulse: got req=%b tt=%h empty=%b we=%b icc=%h expected 1 0a 1 0 0", trap_req, trap_tt, wb_empty, rf_we, icc); end
    idle(1'b1);
    n_checks++;
    if (trap_req !== 1'b0) begin n_fail++; $display("FAIL trap_one_cycle: got %b expected 0", trap_req); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cycle(1'b1, 32'hA0, 4'h0, 32'h0, 1'b0, 2'b00, 6'b000000, 5'd1, 1'b0);
    cycle(1'b1, 32'hA1, 4'h0, 32'h0, 1'b0, 2'b00, 6'b000000, 5'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'hB0 + i, 4'h0, 32'h0, 1'b0, 2'b00, 6'b000000, 5'(10 + i), 1'b1);
      n_checks++;
      if (wb_full !== 1'b1) begin n_fail++; $display("FAIL b2b_full%0d: got %b expected 1", i, wb_full); end
    end
    repeat (3) idle(1'b1);
  endtask

  task automatic test_random();
    logic [5:0] op3_tab [12];
    op3_tab = '{6'b010000, 6'b000000, 6'b001010, 6'b001011, 6'b011010, 6'b011011,
                6'b100100, 6'b110000, 6'b100000, 6'b100010, 6'b010100, 6'b000100};
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      logic [1:0] op;
      logic [5:0] op3;
      logic [4:0] rd;
      op  = ($urandom_range(0, 5) == 0) ? 2'(($urandom_range(0, 1) == 0) ? 0 : 1) : 2'b10;
      op3 = ($urandom_range(0, 7) == 0) ? 6'($urandom) : op3_tab[$urandom_range(0, 11)];
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cycle($urandom_range(0, 9) < 7, $urandom, 4'($urandom), $urandom,
            $urandom_range(0, 15) == 0, op, op3, rd, $urandom_range(0, 9) < 6);
    end
  endtask

  initial begin
    test_reset();
    test_addcc();
    test_umul();
    test_async_reset();
    test_overflow();
    test_trap();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
